// File: rtl/program_memory_arbiter_pkg.sv
// Shared definitions for the program store arbiter: store geometry,
// the idle instruction word and the sequencing state encoding.
package program_memory_arbiter_pkg;

    localparam int PROG_ADDR_W = 4;
    localparam int PROG_DATA_W = 7;
    localparam int PROG_WORDS  = 16;

    // All-zero word decodes as a zero-time WAIT, so it is harmless to the core.
    localparam logic [PROG_DATA_W-1:0] NOP_WORD = 7'h00;

    // Sequencing state, also driven out on STATE for observation.
    typedef enum logic [1:0] {
        HALT    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

endpackage

// File: rtl/program_memory_arbiter_store.sv
// 16 x 7 program register file. One synchronous write port, a combinational
// read port for instruction fetch and a registered read port for the host.
// The two read paths are independent, so host reads never stall the core.
module prog_store_16x7
    import program_memory_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [PROG_ADDR_W-1:0] waddr_i,
    input  logic [PROG_DATA_W-1:0] wdata_i,
    input  logic [PROG_ADDR_W-1:0] craddr_i,
    output logic [PROG_DATA_W-1:0] crdata_o,
    input  logic                   hre_i,
    input  logic [PROG_ADDR_W-1:0] hraddr_i,
    output logic [PROG_DATA_W-1:0] hrdata_o
);

    logic [PROG_DATA_W-1:0] mem_q [PROG_WORDS];
    logic [PROG_DATA_W-1:0] hrdata_q;

    // Storage array: cleared to NOP on reset, one word written per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PROG_WORDS; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Host read register: captures the pre-edge word and holds it until the next read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hrdata_q <= NOP_WORD;
        end else if (hre_i) begin
            hrdata_q <= mem_q[hraddr_i];
        end
    end

    assign crdata_o = mem_q[craddr_i];
    assign hrdata_o = hrdata_q;

endmodule

// File: rtl/program_memory_arbiter.sv
// Program store arbiter: holds the core in reset while the host loads the
// store, releases it after RELEASE_CYCLES settling cycles, and arbitrates host
// accesses against the running core.
//
// Host handshake: HOST_REQ (with WE/ADDR/WDATA) is sampled at a rising edge
// only while HOST_ACK is low; the access happens at that edge and HOST_ACK is
// high for exactly the following cycle, with HOST_ERR/HOST_RDATA valid beside
// it. Writes are only honoured when the pre-edge state is LOAD; elsewhere they
// are acknowledged with HOST_ERR=1 and leave the store untouched.
module program_memory_arbiter
    import program_memory_arbiter_pkg::*;
#(
    parameter int RELEASE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET_LOW,
    input  logic       LOAD_MODE,
    input  logic       HOST_REQ,
    input  logic       HOST_WE,
    input  logic [3:0] HOST_ADDR,
    input  logic [6:0] HOST_WDATA,
    output logic       HOST_ACK,
    output logic       HOST_ERR,
    output logic [6:0] HOST_RDATA,
    input  logic [3:0] CPU_ADDR,
    output logic [6:0] CPU_DATA,
    output logic       CPU_RESET_LOW,
    output logic       LOADED,
    output logic [1:0] STATE
);

    localparam logic [3:0] CNT_LAST = 4'(RELEASE_CYCLES - 1);

    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PROG_WORDS-1:0] mask_q, mask_d;
    logic                  loaded_q;
    logic                  ack_q, err_q;
    logic                  host_accept, host_wr, host_rd;
    logic [6:0]            cpu_rdata;

    // Reset synchroniser: asserts immediately, releases through two flops.
    always_ff @(posedge CLK or negedge RESET_LOW) begin
        if (!RESET_LOW) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign host_accept = HOST_REQ & ~ack_q;
    assign host_wr     = host_accept & HOST_WE & (state_q == LOAD);
    assign host_rd     = host_accept & ~HOST_WE;

    prog_store_16x7 u_store (
        .clk_i    (CLK),
        .rst_ni   (rst_n),
        .we_i     (host_wr),
        .waddr_i  (HOST_ADDR),
        .wdata_i  (HOST_WDATA),
        .craddr_i (CPU_ADDR),
        .crdata_o (cpu_rdata),
        .hre_i    (host_rd),
        .hraddr_i (HOST_ADDR),
        .hrdata_o (HOST_RDATA)
    );

    // State register together with the release counter and written-word mask.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HALT;
            cnt_q    <= '0;
            mask_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            loaded_q <= &mask_d;
        end
    end

    // Next-state logic: mask clears on entry to LOAD from HALT or RUN, not on an aborted release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        unique case (state_q)
            HALT: begin
                if (LOAD_MODE) begin
                    state_d = LOAD;
                    mask_d  = '0;
                end else begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (host_wr) mask_d[HOST_ADDR] = 1'b1;
                if (!LOAD_MODE) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (LOAD_MODE) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (LOAD_MODE) begin
                    state_d = LOAD;
                    mask_d  = '0;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Outputs decoded from the current state: core runs and fetches only in RUN.
    always_comb begin
        CPU_RESET_LOW = 1'b0;
        CPU_DATA      = NOP_WORD;
        if (state_q == RUN) begin
            CPU_RESET_LOW = 1'b1;
            CPU_DATA      = cpu_rdata;
        end
    end

    // Handshake: one-cycle ACK per accepted request; ERR flags a write outside LOAD.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= host_accept;
            err_q <= host_accept & HOST_WE & (state_q != LOAD);
        end
    end

    assign HOST_ACK = ack_q;
    assign HOST_ERR = err_q;
    assign LOADED   = loaded_q;
    assign STATE    = state_q;

endmodule
